// File: rtl/deserializador_rx_if.sv
// deserializador_rx_if: serial input and aligned word output bundle of the comma-aligning deserializer
interface deserializador_rx_if;
  logic enb;
  logic serialIn;
  logic [9:0] dataOut;
  logic validOut;
  logic commaOut;
  logic lock;
  modport master(output enb, serialIn, input dataOut, validOut, commaOut, lock);
  modport slave(input enb, serialIn, output dataOut, validOut, commaOut, lock);
endinterface

// File: rtl/deserializador_rx.sv
// deserializador_rx: serial-to-parallel receiver that aligns on K28.5 commas and delivers 10-bit words while locked
module deserializador_rx #(
  parameter logic [9:0] COMMA_P = 10'b0011111010,
  parameter logic [9:0] COMMA_N = 10'b1100000101,
  parameter int LOCK_COMMAS = 3,
  parameter int UNLOCK_ERRS = 2
) (
  input logic clkRx,
  input logic rst,
  deserializador_rx_if.slave rx
);
  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;
  state_t state, state_n;
  logic [8:0] sr;
  logic [3:0] fill, bit_cnt, bit_cnt_n;
  logic [2:0] comma_cnt, comma_cnt_n, err_cnt, err_cnt_n, comma_inc, err_inc;
  logic [9:0] win, data_n;
  logic valid_n, comma_n, lock_n, is_comma, bnd, acquire;
  assign win = {sr, rx.serialIn};
  assign is_comma = fill >= 4'd9 && (win == COMMA_P || win == COMMA_N);
  assign bnd = bit_cnt == 4'd9;
  assign comma_inc = comma_cnt == 3'd7 ? 3'd7 : comma_cnt + 3'd1;
  assign err_inc = err_cnt == 3'd7 ? 3'd7 : err_cnt + 3'd1;
  // the comma that completes the lock run is delivered as the first word
  assign acquire = is_comma && ((state == HUNT && LOCK_COMMAS == 1) ||
                                (state == ALIGN && bnd && int'(comma_inc) >= LOCK_COMMAS));
  always_comb begin
    state_n = state;
    bit_cnt_n = bnd ? 4'd0 : bit_cnt + 4'd1;
    comma_cnt_n = comma_cnt;
    err_cnt_n = err_cnt;
    data_n = rx.dataOut;
    valid_n = 1'b0;
    comma_n = 1'b0;
    lock_n = rx.lock;
    case (state)
      HUNT: if (is_comma) begin
        bit_cnt_n = 4'd0;
        comma_cnt_n = 3'd1;
        state_n = ALIGN;
      end
      ALIGN: if (is_comma) begin
        bit_cnt_n = bnd ? 4'd0 : 4'd0;
        comma_cnt_n = bnd ? comma_inc : 3'd1;
      end
      LOCKED: if (bnd) begin
        data_n = win;
        valid_n = 1'b1;
        comma_n = is_comma;
        err_cnt_n = is_comma ? 3'd0 : err_cnt;
      end else if (is_comma) begin
        err_cnt_n = err_inc;
        state_n = int'(err_inc) >= UNLOCK_ERRS ? HUNT : LOCKED;
        lock_n = int'(err_inc) < UNLOCK_ERRS;
      end
      default: state_n = HUNT;
    endcase
    if (acquire) begin
      state_n = LOCKED;
      lock_n = 1'b1;
      err_cnt_n = 3'd0;
      data_n = win;
      valid_n = 1'b1;
      comma_n = 1'b1;
    end
  end
  always_ff @(posedge clkRx) begin
    if (rst) begin
      state <= HUNT;
      sr <= '0;
      fill <= '0;
      bit_cnt <= '0;
      comma_cnt <= '0;
      err_cnt <= '0;
      rx.dataOut <= '0;
      rx.validOut <= 1'b0;
      rx.commaOut <= 1'b0;
      rx.lock <= 1'b0;
    end else if (rx.enb) begin
      state <= state_n;
      sr <= win[8:0];
      fill <= fill == 4'd10 ? fill : fill + 4'd1;
      bit_cnt <= bit_cnt_n;
      comma_cnt <= comma_cnt_n;
      err_cnt <= err_cnt_n;
      rx.dataOut <= data_n;
      rx.validOut <= valid_n;
      rx.commaOut <= comma_n;
      rx.lock <= lock_n;
    end else begin
      rx.validOut <= 1'b0;
      rx.commaOut <= 1'b0;
    end
  end
endmodule

// File: tb/tb_deserializador_rx.sv
// tb_deserializador_rx: random and directed stimulus checked by a scoreboard fed from a bit-index alignment model
module tb_deserializador_rx;
  localparam logic [9:0] CP = 10'b0011111010;
  localparam logic [9:0] CN = 10'b1100000101;
  localparam int LC = 3;
  localparam int UE = 2;
  typedef struct {int cyc; logic [9:0] data; logic comma;} exp_t;
  logic clkRx = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  exp_t dq[$];
  logic lq[$];
  exp_t x;
  int mode = 0, nb = 0, anchor = 0, cc = 0, ec = 0;
  logic [9:0] w = '0;
  logic m_lock = 1'b0;
  deserializador_rx_if rx();
  deserializador_rx dut (.clkRx(clkRx), .rst(rst), .rx(rx));
  always #5 clkRx = ~clkRx;
  always @(posedge clkRx) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic lock_up();
    mode = 2;
    m_lock = 1'b1;
    ec = 0;
    dq.push_back('{cyc + 1, w, 1'b1});
  endtask
  // word boundaries sit every 10 accepted bits after the anchoring comma
  task automatic model(input logic b, input logic e, input logic r);
    logic com, bnd;
    if (r) begin
      mode = 0; nb = 0; anchor = 0; cc = 0; ec = 0; w = '0; m_lock = 1'b0;
    end else if (e) begin
      w = {w[8:0], b};
      nb++;
      com = nb >= 10 && (w == CP || w == CN);
      bnd = nb > anchor && (nb - anchor) % 10 == 0;
      if (mode == 0) begin
        if (com) begin
          anchor = nb; cc = 1;
          if (LC == 1) lock_up(); else mode = 1;
        end
      end else if (mode == 1) begin
        if (com && bnd) begin
          cc++;
          if (cc >= LC) lock_up();
        end else if (com) begin
          anchor = nb; cc = 1;
        end
      end else if (bnd) begin
        dq.push_back('{cyc + 1, w, com});
        if (com) ec = 0;
      end else if (com) begin
        ec++;
        if (ec >= UE) begin mode = 0; m_lock = 1'b0; end
      end
    end
  endtask
  task automatic step(input logic b, input logic e, input logic r);
    @(negedge clkRx);
    rx.serialIn = b;
    rx.enb = e;
    rst = r;
    model(b, e, r);
    lq.push_back(m_lock);
  endtask
  task automatic send(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0);
  endtask
  task automatic peek();
    @(posedge clkRx);
    #1;
  endtask
  initial begin
    rx.enb = 1'b0;
    rx.serialIn = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    send(10'b0011111010, 8);
    peek();
    check("fill_lock", rx.lock, 0);
    check("fill_valid", rx.validOut, 0);
    send(10'($urandom_range(0, 7)), 3);
    send(CP, 10); send(10'b1010101010, 10); send(CN, 10); send(CP, 10);
    peek();
    check("acq_lock", rx.lock, 1);
    check("acq_valid", rx.validOut, 1);
    check("acq_data", rx.dataOut, CP);
    check("acq_comma", rx.commaOut, 1);
    send(10'b1010101010, 10); send(10'b0110001011, 10);
    peek();
    check("data_word", rx.dataOut, 10'b0110001011);
    check("data_comma", rx.commaOut, 0);
    send(10'b10101, 5); send(CP, 10); send(10'b10101, 5); send(CP, 10);
    peek();
    check("single_err_lock", rx.lock, 1);
    send(10'b10101, 5); send(CP, 10);
    peek();
    check("first_err_lock", rx.lock, 1);
    send(CP, 10);
    peek();
    check("unlock", rx.lock, 0);
    send(CP, 10); send(10'b101, 3); send(CP, 10); send(CP, 10);
    peek();
    check("realign_nolock", rx.lock, 0);
    send(CP, 10);
    peek();
    check("realign_lock", rx.lock, 1);
    for (int i = 9; i >= 6; i--) step(CN[i] ^ 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 5; i >= 0; i--) step(i[0], 1'b1, 1'b0);
    send(CN, 10);
    step(1'b0, 1'b1, 1'b1);
    peek();
    check("rst_lock", rx.lock, 0);
    check("rst_valid", rx.validOut, 0);
    for (int k = 0; k < 80; k++) begin
      logic [9:0] v;
      int s;
      s = $urandom_range(0, 3);
      v = s == 0 ? CP : s == 1 ? CN : 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) send(10'($urandom), $urandom_range(1, 4));
      for (int i = 9; i >= 0; i--) begin
        while ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, 1'b0);
        step(v[i], 1'b1, 1'b0);
      end
      if ($urandom_range(0, 59) == 0) step(1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0);
    peek();
    peek();
    checks++;
    if (dq.size() != 0) begin
      errors++;
      $display("FAIL pending_words: %0d words never delivered, expected 0", dq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial forever begin
    @(posedge clkRx);
    #1;
    if (lq.size() > 0) begin
      check("lock", rx.lock, lq.pop_front());
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: validOut 0 at cycle %0d, expected 1 with data %0h", dq[0].cyc, dq[0].data);
        void'(dq.pop_front());
      end
      if (rx.validOut === 1'b1) begin
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          x = dq.pop_front();
          check("data", rx.dataOut, x.data);
          check("comma", rx.commaOut, x.comma);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid at cycle %0d: validOut 1 data %0h, expected validOut 0", cyc, rx.dataOut);
        end
      end else begin
        check("valid_idle", rx.validOut, 0);
        check("comma_idle", rx.commaOut, 0);
      end
    end
  end
endmodule
